// File: rtl/shift_rx.sv
// ---------------------------------------------------------------------------
// shift_rx -- serial-to-parallel receiver for the 4-wire display shift bus.
//
// Oversamples the bus {sck, sdat, oe, clrn} on clk and rebuilds each frame
// as a WIDTH-bit word. A rising oe latches the word, like the 74HC595
// storage register on the board.
//
// Configuration macro: SHIFTRX_GLITCH_FILTER_EN
//   Defined   : synced sck/oe must hold a new level for 2 clk before an edge
//               is accepted. Every latency grows by 1 clk.
//   Undefined : no filter.
//
// Ports
//   clk       in   1      receiver clock, >= 4x tx clock (6x with filter)
//   rst_n     in   1      asynchronous reset, active low
//   sin       in   4      serial bus {sck, sdat, oe, clrn}, async to clk
//   pdata     out  WIDTH  last latched frame, first bit in pdata[WIDTH-1]
//   valid     out  1      one-cycle pulse when pdata updates
//   frame_err out  1      sticky, set when a latch sees bit count != WIDTH
//   err_clr   in   1      synchronous clear of frame_err (set wins)
//   bit_cnt   out  CNTW   sck rises since last latch/clear, saturating
// ---------------------------------------------------------------------------
module shift_rx #(
  parameter int WIDTH = 64,
  parameter int CNTW  = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       sin,
  output logic [WIDTH-1:0] pdata,
  output logic             valid,
  output logic             frame_err,
  input  logic             err_clr,
  output logic [CNTW-1:0]  bit_cnt
);

  // Idle bus: sck=0, sdat=0, oe=1, clrn=1
  localparam logic [3:0]      SIN_IDLE = 4'b0011;
  localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(WIDTH);

  logic [3:0]       meta_r;
  logic [3:0]       sync_r;
  logic             sck_d_r;
  logic             oe_d_r;
  logic             sck_rise_s;
  logic             oe_rise_s;
  logic             sdat_s;
  logic             clrn_s;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] shift_nxt_s;
  logic [CNTW-1:0]  cnt_nxt_s;
  logic             latch_pend_r;
  logic             latch_upd_s;
  logic             err_set_s;

  assign clrn_s = sync_r[0];

  // Two-flop synchronisers plus one delayed copy of sck/oe for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r  <= SIN_IDLE;
      sync_r  <= SIN_IDLE;
      sck_d_r <= 1'b0;
      oe_d_r  <= 1'b1;
    end else begin
      meta_r  <= sin;
      sync_r  <= meta_r;
      sck_d_r <= sync_r[3];
      oe_d_r  <= sync_r[1];
    end
  end

`ifdef SHIFTRX_GLITCH_FILTER_EN
  logic sck_f_r;
  logic oe_f_r;
  logic sdat_d_r;
  logic sck_f_s;
  logic oe_f_s;

  // A filtered level follows the synced line only once two samples agree;
  // sdat gets one extra delay so it stays aligned with the filtered sck.
  always_comb begin
    sck_f_s = sck_f_r;
    oe_f_s  = oe_f_r;
    if (sync_r[3] == sck_d_r) begin
      sck_f_s = sync_r[3];
    end else begin
      sck_f_s = sck_f_r;
    end
    if (sync_r[1] == oe_d_r) begin
      oe_f_s = sync_r[1];
    end else begin
      oe_f_s = oe_f_r;
    end
    sck_rise_s = sck_f_s & ~sck_f_r;
    oe_rise_s  = oe_f_s & ~oe_f_r;
    sdat_s     = sdat_d_r;
  end

  // Filtered level history and delayed sdat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_f_r  <= 1'b0;
      oe_f_r   <= 1'b1;
      sdat_d_r <= 1'b0;
    end else begin
      sck_f_r  <= sck_f_s;
      oe_f_r   <= oe_f_s;
      sdat_d_r <= sync_r[2];
    end
  end
`else
  // Unfiltered edge detection on the synced lines
  always_comb begin
    sck_rise_s = sync_r[3] & ~sck_d_r;
    oe_rise_s  = sync_r[1] & ~oe_d_r;
    sdat_s     = sync_r[2];
  end
`endif

  // Next shift/count: clrn low dominates; a pending latch restarts the count,
  // keeping any sck rise that lands in the same cycle.
  always_comb begin
    shift_nxt_s = shift_r;
    cnt_nxt_s   = bit_cnt;
    if (!clrn_s) begin
      shift_nxt_s = {WIDTH{1'b0}};
      cnt_nxt_s   = CNT_ZERO;
    end else if (sck_rise_s) begin
      shift_nxt_s = {shift_r[WIDTH-2:0], sdat_s};
      if (latch_pend_r) begin
        cnt_nxt_s = CNT_ONE;
      end else if (bit_cnt != CNT_MAX) begin
        cnt_nxt_s = bit_cnt + CNT_ONE;
      end else begin
        cnt_nxt_s = bit_cnt;
      end
    end else if (latch_pend_r) begin
      cnt_nxt_s = CNT_ZERO;
    end else begin
      cnt_nxt_s = bit_cnt;
    end
  end

  // Latch decisions use the count one cycle after the oe edge, which already
  // includes an sck rise detected in the same cycle as the oe rise.
  always_comb begin
    latch_upd_s = latch_pend_r && (bit_cnt != CNT_ZERO);
    err_set_s   = latch_pend_r && (bit_cnt != CNT_FULL);
  end

  // Shift register, counter, latch and error state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r      <= {WIDTH{1'b0}};
      bit_cnt      <= CNT_ZERO;
      latch_pend_r <= 1'b0;
      pdata        <= {WIDTH{1'b0}};
      valid        <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      shift_r      <= shift_nxt_s;
      bit_cnt      <= cnt_nxt_s;
      latch_pend_r <= oe_rise_s;
      valid        <= latch_upd_s;
      if (latch_upd_s) begin
        pdata <= shift_r;
      end
      if (err_set_s) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_rx.sv
// ---------------------------------------------------------------------------
// tb_shift_rx -- scoreboard bench for shift_rx.
// Stimulus pushes the expected frame into exp_q before each latch; a monitor
// pops and compares on every valid pulse. Bus is driven at 8 clk per tx bit.
// ---------------------------------------------------------------------------
module tb_shift_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        sdat = 1'b0;
  logic        oe = 1'b1;
  logic        clrn = 1'b1;
  logic        err_clr = 1'b0;
  logic [3:0]  sin;
  logic [63:0] pdata;
  logic        valid;
  logic        frame_err;
  logic [6:0]  bit_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] data;
    logic        err;
    logic        chk_data;
  } exp_t;

  exp_t exp_q[$];

  assign sin = {sck, sdat, oe, clrn};

  always #5 clk = ~clk;

  shift_rx #(.WIDTH(64), .CNTW(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .pdata     (pdata),
    .valid     (valid),
    .frame_err (frame_err),
    .err_clr   (err_clr),
    .bit_cnt   (bit_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input logic [63:0] d, input logic e, input logic c);
    exp_t x;
    x.data     = d;
    x.err      = e;
    x.chk_data = c;
    exp_q.push_back(x);
  endtask

  // One tx bit: 4 clk low, 4 clk high; optional 1-clk sck glitch in low phase
  task automatic send_bit(input logic b, input logic glitch);
    sck  = 1'b0;
    sdat = b;
    if (glitch) begin
      repeat (2) @(negedge clk);
      sck = 1'b1;
      @(negedge clk);
      sck = 1'b0;
      @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
    sck = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_word(input logic [63:0] w, input int n, input logic glitch);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i], glitch);
    sck = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic latch();
    sck = 1'b0;
    oe  = 1'b0;
    repeat (4) @(negedge clk);
    oe = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every valid pulse must match the oldest expected frame
  always @(negedge clk) begin
    if (rst_n && valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid actual pdata=%h required no pulse", pdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ((e.chk_data && (pdata !== e.data)) || (frame_err !== e.err)) begin
          errors++;
          $display("FAIL frame actual pdata=%h err=%b required pdata=%h err=%b",
                   pdata, frame_err, e.data, e.err);
        end
      end
    end
  end

  initial begin
    logic [63:0] ones;
    logic [63:0] glw;
    ones = {64{1'b1}};
    glw  = 64'h0F1E_2D3C_4B5A_6978;

    // Reset with idle bus
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_pdata", pdata, 64'h0);
    check("reset_valid", {63'h0, valid}, 64'h0);
    check("reset_err", {63'h0, frame_err}, 64'h0);
    check("reset_cnt", {57'h0, bit_cnt}, 64'h0);

    // Nominal frame
    send_word(64'hDEAD_BEEF_0123_4567, 64, 1'b0);
    check("nominal_cnt", {57'h0, bit_cnt}, 64'd64);
    push(64'hDEAD_BEEF_0123_4567, 1'b0, 1'b1);
    latch();
    check("nominal_err", {63'h0, frame_err}, 64'h0);
    check("nominal_cnt_after", {57'h0, bit_cnt}, 64'h0);

    // Short frame: shift reg keeps older bits, so pdata = old word << 10 | new
    send_word(64'h0000_0000_0000_02A5, 10, 1'b0);
    check("short_cnt", {57'h0, bit_cnt}, 64'd10);
    push((64'hDEAD_BEEF_0123_4567 << 10) | 64'h2A5, 1'b1, 1'b1);
    latch();
    check("short_cnt_after", {57'h0, bit_cnt}, 64'h0);
    check("short_err", {63'h0, frame_err}, 64'h1);
    pulse_err_clr();
    check("err_clr", {63'h0, frame_err}, 64'h0);

    // Mid-frame clear
    send_word(64'h0000_0000_000A_BCDE, 20, 1'b0);
    check("mid_cnt", {57'h0, bit_cnt}, 64'd20);
    clrn = 1'b0;
    repeat (24) @(negedge clk);
    check("clr_cnt", {57'h0, bit_cnt}, 64'h0);
    clrn = 1'b1;
    repeat (4) @(negedge clk);
    send_word(ones, 64, 1'b0);
    push(ones, 1'b0, 1'b1);
    latch();
    check("clr_err", {63'h0, frame_err}, 64'h0);

    // Back-to-back frames
    push(64'h5555_5555_5555_5555, 1'b0, 1'b1);
    send_word(64'h5555_5555_5555_5555, 64, 1'b0);
    latch();
    push(64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b1);
    send_word(64'hAAAA_AAAA_AAAA_AAAA, 64, 1'b0);
    latch();

    // Empty latch: no valid, but sets frame_err
    latch();
    check("empty_err", {63'h0, frame_err}, 64'h1);
    pulse_err_clr();

    // Glitched frame
    send_word(glw, 64, 1'b1);
`ifdef SHIFTRX_GLITCH_FILTER_EN
    check("glitch_cnt", {57'h0, bit_cnt}, 64'd64);
    push(glw, 1'b0, 1'b1);
    latch();
    check("glitch_err", {63'h0, frame_err}, 64'h0);
`else
    // every bit counted twice: 128 rises saturate at 127
    check("glitch_cnt", {57'h0, bit_cnt}, 64'd127);
    push(64'h0, 1'b1, 1'b0);
    latch();
    check("glitch_err", {63'h0, frame_err}, 64'h1);
`endif

    // Drain: every pushed frame must have been seen
    repeat (20) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'h0);

    // Reset mid-frame discards state
    send_word(64'h0000_0000_0000_001B, 5, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_pdata", pdata, 64'h0);
    check("rst_mid_cnt", {57'h0, bit_cnt}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
